// File: rtl/snn_sched_pkg.sv
// Shared types for the neuron time-step scheduler: FSM state encoding and
// the default neuron index width.
package snn_sched_pkg;

  localparam int NUM_NEURONS_DEF = 256;
  localparam int NEURON_IDX_W    = $clog2(NUM_NEURONS_DEF);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EVAL  = 3'd2,
    S_WRITE = 3'd3,
    S_SPIKE = 3'd4,
    S_DONE  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/neuron_scheduler.sv
// Walks neurons 0..NUM_NEURONS-1 per time step: SRAM read, neuron-block eval,
// potential write-back, spike handshake. SCHED_SPIKE_COUNT_EN adds spike_count_o.
module neuron_scheduler
  import snn_sched_pkg::*;
#(
  parameter int NUM_NEURONS     = 256,
  parameter int NUM_AXONS       = 256,
  parameter int POTENTIAL_WIDTH = 9
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               start_i,
  input  logic [NUM_AXONS-1:0]               axon_in_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               mem_rd_en_o,
  output logic [$clog2(NUM_NEURONS)-1:0]     mem_addr_o,
  output logic [NUM_AXONS-1:0]               nb_axon_o,
  input  logic [POTENTIAL_WIDTH-1:0]         nb_potential_i,
  input  logic                               nb_spike_i,
  output logic                               pot_we_o,
  output logic [POTENTIAL_WIDTH-1:0]         pot_wdata_o,
  output logic                               spike_valid_o,
  input  logic                               spike_ready_i,
`ifdef SCHED_SPIKE_COUNT_EN
  output logic [$clog2(NUM_NEURONS):0]       spike_count_o,
`endif
  output logic [$clog2(NUM_NEURONS)-1:0]     spike_idx_o
);

  localparam int IW = $clog2(NUM_NEURONS);

  sched_state_e                 state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_AXONS-1:0]         axon_q;
  logic [POTENTIAL_WIDTH-1:0]   pot_q;
  logic                         spk_q;
  logic                         accept, advance, last;

  assign accept  = (state_q == S_IDLE) && start_i;
  // A neuron is finished once written with no spike, or once its spike transfers.
  assign advance = ((state_q == S_WRITE) && !spk_q) ||
                   ((state_q == S_SPIKE) && spike_ready_i);
  assign last    = (idx_q == IW'(NUM_NEURONS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE:  if (start_i) begin
                 state_d = S_READ;
                 idx_d   = '0;
               end
      S_READ:  state_d = S_EVAL;
      S_EVAL:  state_d = S_WRITE;
      S_WRITE: if (spk_q) state_d = S_SPIKE;
      S_SPIKE: ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (last) state_d = S_DONE;
      else begin
        state_d = S_READ;
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      axon_q  <= '0;
      pot_q   <= '0;
      spk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) axon_q <= axon_in_i;
      if (state_q == S_EVAL) begin
        pot_q <= nb_potential_i;
        spk_q <= nb_spike_i;
      end
    end
  end

`ifdef SCHED_SPIKE_COUNT_EN
  logic [IW:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                      cnt_q <= '0;
    else if (accept)                                   cnt_q <= '0;
    else if ((state_q == S_SPIKE) && spike_ready_i)    cnt_q <= cnt_q + 1'b1;
  end
  assign spike_count_o = cnt_q;
`endif

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign mem_rd_en_o   = (state_q == S_READ);
  assign mem_addr_o    = idx_q;
  assign nb_axon_o     = axon_q;
  assign pot_we_o      = (state_q == S_WRITE);
  assign pot_wdata_o   = pot_q;
  assign spike_valid_o = (state_q == S_SPIKE);
  assign spike_idx_o   = idx_q;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Scoreboard bench for neuron_scheduler (4 neurons); stimulus pushes expected
// read/write/spike/done events with their cycle, a monitor pops and compares.
module tb_neuron_scheduler;

  localparam int NN = 4;
  localparam int NA = 8;
  localparam int PW = 9;
  localparam int IW = 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [NA-1:0] axon_in_i = '0;
  logic          busy_o, done_o, mem_rd_en_o, pot_we_o, spike_valid_o;
  logic [IW-1:0] mem_addr_o, spike_idx_o;
  logic [NA-1:0] nb_axon_o;
  logic [PW-1:0] nb_potential_i, pot_wdata_o;
  logic          nb_spike_i;
  logic          spike_ready_i = 1'b0;
`ifdef SCHED_SPIKE_COUNT_EN
  logic [IW:0]   spike_count_o;
`endif

  neuron_scheduler #(.NUM_NEURONS(NN), .NUM_AXONS(NA), .POTENTIAL_WIDTH(PW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .axon_in_i(axon_in_i),
    .busy_o(busy_o), .done_o(done_o), .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .nb_axon_o(nb_axon_o), .nb_potential_i(nb_potential_i), .nb_spike_i(nb_spike_i),
    .pot_we_o(pot_we_o), .pot_wdata_o(pot_wdata_o), .spike_valid_o(spike_valid_o),
    .spike_ready_i(spike_ready_i),
`ifdef SCHED_SPIKE_COUNT_EN
    .spike_count_o(spike_count_o),
`endif
    .spike_idx_o(spike_idx_o));

  always #5 clk_i = ~clk_i;

  typedef struct { int kind; int idx; int data; int cyc; } ev_t; // 0 wr,1 spk,2 done,3 rd
  ev_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  int stall_cfg = 0, wait_cnt = 0;
  logic [NN-1:0] spk_mask = '0;
  logic [IW-1:0] rd_q = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [PW-1:0] model_pot(input int idx, input logic [NA-1:0] ax);
    return PW'(idx * 101 + int'(ax));
  endfunction

  // Neuron block + SRAM model: data for the read address is seen in EVAL.
  always @(posedge clk_i) if (mem_rd_en_o) rd_q <= mem_addr_o;
  assign nb_potential_i = model_pot(int'(rd_q), nb_axon_o);
  assign nb_spike_i     = spk_mask[rd_q];

  // Consumer: holds ready low for stall_cfg cycles of each spike_valid_o.
  initial forever begin
    @(posedge clk_i); #1;
    if (spike_valid_o) begin
      if (wait_cnt >= stall_cfg) spike_ready_i = 1'b1;
      else begin spike_ready_i = 1'b0; wait_cnt++; end
    end else begin
      wait_cnt = 0;
      spike_ready_i = (stall_cfg == 0);
    end
  end

  task automatic check_ev(input int kind, input int idx, input int data);
    ev_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event kind=%0d idx=%0d data=%0d cyc=%0d, required none", kind, idx, data, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.idx != idx || e.data != data || e.cyc != cyc) begin
        fails++;
        $display("FAIL event got kind=%0d idx=%0d data=%0d cyc=%0d, required kind=%0d idx=%0d data=%0d cyc=%0d",
                 kind, idx, data, cyc, e.kind, e.idx, e.data, e.cyc);
      end
    end
  endtask

  // Monitor
  initial begin
    logic pv; logic [IW-1:0] pidx; int cnt;
    pv = 1'b0; pidx = '0;
    forever begin
      @(negedge clk_i); #2;
      if (rst_n_i) begin
        if (spike_valid_o && pv) begin
          tests++;
          if (spike_idx_o != pidx) begin
            fails++;
            $display("FAIL spike_hold idx=%0d, required %0d", spike_idx_o, pidx);
          end
        end
        pv = spike_valid_o && !spike_ready_i; pidx = spike_idx_o;
        if (mem_rd_en_o) check_ev(3, int'(mem_addr_o), int'(nb_axon_o));
        if (pot_we_o) check_ev(0, int'(mem_addr_o), int'(pot_wdata_o));
        if (spike_valid_o && spike_ready_i) check_ev(1, int'(spike_idx_o), 0);
        if (done_o) begin
          cnt = 0;
`ifdef SCHED_SPIKE_COUNT_EN
          cnt = int'(spike_count_o);
`endif
          check_ev(2, 0, cnt);
        end
      end else pv = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int outs_or();
    int r;
    r = int'(busy_o) | int'(done_o) | int'(mem_rd_en_o) | int'(mem_addr_o) | int'(nb_axon_o) |
        int'(pot_we_o) | int'(pot_wdata_o) | int'(spike_valid_o) | int'(spike_idx_o);
`ifdef SCHED_SPIKE_COUNT_EN
    r = r | int'(spike_count_o);
`endif
    return r;
  endfunction

  task automatic run_step(input logic [NA-1:0] ax, input logic [NN-1:0] mask, input int stall,
                          input int extra, input int rst_at, input bit start_done);
    int c0, t, done_rel, k, pc;
    spk_mask = mask; stall_cfg = stall;
    @(negedge clk_i);
    c0 = cyc; t = c0; pc = 0;
    for (int i = 0; i < NN; i++) begin
      q.push_back('{3, i, int'(ax), t + 1});
      q.push_back('{0, i, int'(model_pot(i, ax)), t + 3});
      t += 3;
      if (mask[i]) begin
        t += 1 + stall;
        q.push_back('{1, i, 0, t});
        pc++;
      end
    end
`ifdef SCHED_SPIKE_COUNT_EN
    q.push_back('{2, 0, pc, t + 1});
`else
    q.push_back('{2, 0, 0, t + 1});
`endif
    done_rel = t + 1 - c0;
    start_i = 1'b1; axon_in_i = ax;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      k = cyc - c0;
      start_i = 1'b0; axon_in_i = ax;
      if (k == extra) begin start_i = 1'b1; axon_in_i = ~ax; end
      if (start_done && k == done_rel) start_i = 1'b1;
      if (start_done && k == done_rel + 1) begin
        #1 chk("start_at_done_busy", int'(busy_o), 0);
        chk("start_at_done_rd", int'(mem_rd_en_o), 0);
      end
`ifdef SCHED_SPIKE_COUNT_EN
      if (k == 1) begin #1 chk("count_cleared", int'(spike_count_o), 0); end
`endif
      if (rst_at != 0 && k == rst_at) begin
        rst_n_i = 1'b0; q.delete();
        #1 chk("reset_mid_outs", outs_or(), 0);
        for (int r = 0; r < 2; r++) begin
          @(negedge clk_i); #1 chk("reset_hold_outs", outs_or(), 0);
        end
        rst_n_i = 1'b1;
        @(negedge clk_i); #1 chk("post_reset_idle", outs_or(), 0);
        return;
      end
      if (k >= done_rel + 2) break;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    #1 chk("reset_outs", outs_or(), 0);
    rst_n_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i); #1 chk("idle_outs", outs_or(), 0);
    end
    run_step(8'hA5, 4'b0000, 0, 0, 0, 1'b1);  // no spikes, start at done dropped
    run_step(8'h3C, 4'b0100, 5, 0, 0, 1'b0);  // neuron 2 spikes, 5 stall cycles
    run_step(8'h5A, 4'b0000, 0, 5, 0, 1'b0);  // start while busy ignored
    run_step(8'h77, 4'b0000, 0, 0, 5, 1'b0);  // reset in neuron 1 EVAL
    run_step(8'h81, 4'b1001, 0, 0, 0, 1'b0);  // neurons 0 and 3 spike
    run_step(8'h0F, 4'b0000, 0, 0, 0, 1'b0);  // count restarts
    repeat (3) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
